pulse_seq_ctrl: RTL and testbench

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_pkg.sv | 19 +
 rtl/mask_next_sel.sv | 38 +++
 rtl/pulse_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared definitions for the pulse sequencer.
//   pulse_state_e : sequencer FSM state encoding
//   HOLD_LEN      : cycles io_chBusy is ignored after a launch
//   HOLD_W        : width of the hold counter
package pulse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_HOLD   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_GAP    = 3'd4,
      ST_NEXT   = 3'd5
   } pulse_state_e;

   localparam int HOLD_LEN = 2;
   localparam int HOLD_W   = 2;

endpackage

// File: rtl/mask_next_sel.sv
// mask_next_sel: combinational next-set-bit search.
//   mask_i : channel mask
//   cur_i  : current channel index
//   nxt_o  : next higher set bit above cur_i, else the lowest set bit, else 0
//   wrap_o : no higher set bit exists and the mask is nonzero (search wrapped)
module mask_next_sel #(
   parameter int CH_NUM = 4
) (
   input  logic [CH_NUM-1:0] mask_i,
   input  logic [3:0]        cur_i,
   output logic [3:0]        nxt_o,
   output logic              wrap_o
);

   logic       hi_found, lo_found;
   logic [3:0] hi_idx, lo_idx;

   // Scan downward so the last hit is the lowest qualifying bit.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            lo_found = 1'b1;
            lo_idx   = 4'(i);
            if (i > int'(cur_i)) begin
               hi_found = 1'b1;
               hi_idx   = 4'(i);
            end
         end
      end
      nxt_o  = hi_found ? hi_idx : lo_idx;
      wrap_o = !hi_found && lo_found;
   end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: launches the masked pulse channels one after another,
// waiting for each to finish plus a configurable gap, for a number of passes.
//   io_clk, io_rst_n : clock, async active-low reset
//   io_start/io_abort: start (rising edge), abort (level)
//   io_chMask/io_gap/io_loopCnt : sequence config, latched at start
//   io_chBusy        : per-channel activity from the channels
//   io_chEn          : one-cycle launch strobe per channel
//   io_busy/io_done/io_aborted : status and strobes
//   io_curCh/io_passCnt : current channel, completed passes
module pulse_seq_ctrl
   import pulse_pkg::*;
#(
   parameter int CH_NUM     = 4,
   parameter int _RAM_WIDTH = 32
) (
   input  logic                  io_clk,
   input  logic                  io_rst_n,
   input  logic                  io_start,
   input  logic                  io_abort,
   input  logic [CH_NUM-1:0]     io_chMask,
   input  logic [_RAM_WIDTH-1:0] io_gap,
   input  logic [15:0]           io_loopCnt,
   input  logic [CH_NUM-1:0]     io_chBusy,
   output logic [CH_NUM-1:0]     io_chEn,
   output logic                  io_busy,
   output logic                  io_done,
   output logic                  io_aborted,
   output logic [3:0]            io_curCh,
   output logic [15:0]           io_passCnt
);

   pulse_state_e          state_q;
   logic                  start_prev_q;
   logic [CH_NUM-1:0]     mask_q;
   logic [_RAM_WIDTH-1:0] gap_q, gap_cnt_q;
   logic [15:0]           loop_q, pass_q;
   logic [3:0]            cur_q;
   logic [HOLD_W-1:0]     hold_cnt_q;
   logic [CH_NUM-1:0]     chen_q;
   logic                  done_q, aborted_q;

   logic       start_edge, busy_cur;
   logic [3:0] nxt_idx, low_idx;
   logic       nxt_wrap, mask_nz;
   logic [15:0] pass_inc;

   assign start_edge = io_start && !start_prev_q;
   assign busy_cur   = |(io_chBusy & (CH_NUM'(1) << cur_q));
   assign pass_inc   = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;

   mask_next_sel #(.CH_NUM(CH_NUM)) u_next (
      .mask_i (mask_q),
      .cur_i  (cur_q),
      .nxt_o  (nxt_idx),
      .wrap_o (nxt_wrap)
   );

   // Searching above the top index always wraps, giving the lowest set bit;
   // the wrap flag doubles as a nonzero-mask indication.
   mask_next_sel #(.CH_NUM(CH_NUM)) u_low (
      .mask_i (io_chMask),
      .cur_i  (4'(CH_NUM - 1)),
      .nxt_o  (low_idx),
      .wrap_o (mask_nz)
   );

   always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b1;   // start held high through reset is not an edge
         mask_q       <= '0;
         gap_q        <= '0;
         gap_cnt_q    <= '0;
         loop_q       <= '0;
         pass_q       <= '0;
         cur_q        <= '0;
         hold_cnt_q   <= '0;
         chen_q       <= '0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         start_prev_q <= io_start;
         chen_q       <= '0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (start_edge && !io_abort) begin
               mask_q <= io_chMask;
               gap_q  <= io_gap;
               loop_q <= io_loopCnt;
               pass_q <= '0;
               cur_q  <= low_idx;
               if (!mask_nz) begin
                  done_q <= 1'b1;
               end else begin
                  chen_q  <= CH_NUM'(1) << low_idx;
                  state_q <= ST_LAUNCH;
               end
            end
         end else if (io_abort) begin
            // Abort outranks completion and any pending launch.
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
         end else begin
            case (state_q)
               ST_LAUNCH: begin
                  hold_cnt_q <= '0;
                  state_q    <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (hold_cnt_q == HOLD_W'(HOLD_LEN - 1)) state_q <= ST_WAIT;
                  else hold_cnt_q <= hold_cnt_q + 1'b1;
               end
               ST_WAIT: begin
                  if (!busy_cur) begin
                     if (gap_q != '0) begin
                        gap_cnt_q <= gap_q;
                        state_q   <= ST_GAP;
                     end else begin
                        state_q <= ST_NEXT;
                     end
                  end
               end
               ST_GAP: begin
                  if (gap_cnt_q == _RAM_WIDTH'(1)) state_q <= ST_NEXT;
                  else gap_cnt_q <= gap_cnt_q - 1'b1;
               end
               ST_NEXT: begin
                  if (nxt_wrap) pass_q <= pass_inc;
                  if (nxt_wrap && loop_q != '0 && pass_inc == loop_q) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     cur_q   <= nxt_idx;
                     chen_q  <= CH_NUM'(1) << nxt_idx;
                     state_q <= ST_LAUNCH;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign io_chEn    = chen_q;
   assign io_busy    = (state_q != ST_IDLE);
   assign io_done    = done_q;
   assign io_aborted = aborted_q;
   assign io_curCh   = cur_q;
   assign io_passCnt = pass_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb_pulse_seq_ctrl: randomized and directed sequences against an
// event-schedule reference model (launch times derived from busy fall,
// gap and fixed launch/hold overhead).
module tb_pulse_seq_ctrl;

   localparam int MAXC = 512;
   localparam int NONE = 1 << 20;

   logic        io_clk = 1'b0;
   logic        io_rst_n;
   logic        io_start, io_abort;
   logic [3:0]  io_chMask;
   logic [31:0] io_gap;
   logic [15:0] io_loopCnt;
   logic [3:0]  io_chBusy;
   logic [3:0]  io_chEn;
   logic        io_busy, io_done, io_aborted;
   logic [3:0]  io_curCh;
   logic [15:0] io_passCnt;

   int n_chk = 0;
   int n_err = 0;

   logic [3:0] e_chen [MAXC];
   logic [3:0] drv    [MAXC];
   bit         e_busy [MAXC];
   bit         e_done [MAXC];
   bit         e_abt  [MAXC];

   pulse_seq_ctrl #(.CH_NUM(4), ._RAM_WIDTH(32)) dut (
      .io_clk     (io_clk),
      .io_rst_n   (io_rst_n),
      .io_start   (io_start),
      .io_abort   (io_abort),
      .io_chMask  (io_chMask),
      .io_gap     (io_gap),
      .io_loopCnt (io_loopCnt),
      .io_chBusy  (io_chBusy),
      .io_chEn    (io_chEn),
      .io_busy    (io_busy),
      .io_done    (io_done),
      .io_aborted (io_aborted),
      .io_curCh   (io_curCh),
      .io_passCnt (io_passCnt)
   );

   always #5 io_clk = ~io_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Schedule, relative to the start-edge cycle 0: launch at t, the channel's
   // busy is high in [t+d, t+d+len), it is first sampled 3 cycles after the
   // launch, and the next launch comes gap+2 cycles after busy is seen low.
   task automatic build(input logic [3:0] mask, input int gap, input int loopc,
                        input int d, input int len, input int a,
                        output int endc, output int pass);
      int t, z, nx, hi;
      bit fin;
      for (int c = 0; c < MAXC; c++) begin
         e_chen[c] = '0; drv[c] = '0; e_busy[c] = 0; e_done[c] = 0; e_abt[c] = 0;
      end
      pass = 0;
      endc = 1;
      hi   = 0;
      for (int ch = 0; ch < 4; ch++) if (mask[ch]) hi = ch;
      if (mask == 0) begin
         e_done[1] = 1;
      end else begin
         t = 1;
         fin = 0;
         while (!fin) begin
            for (int ch = 0; ch < 4 && !fin; ch++) begin
               if (mask[ch]) begin
                  e_chen[t] = 4'(1 << ch);
                  for (int c = t + d; c < t + d + len && c < MAXC; c++) drv[c][ch] = 1'b1;
                  z = t + 3;
                  while (z < MAXC - 1 && drv[z][ch]) z++;
                  nx = z + gap + 1;
                  if (nx >= a) begin
                     e_abt[a + 1] = 1;
                     endc = a + 1;
                     fin = 1;
                  end else if (ch == hi) begin
                     pass++;
                     if (loopc != 0 && pass == loopc) begin
                        e_done[nx + 1] = 1;
                        endc = nx + 1;
                        fin = 1;
                     end
                  end
                  t = nx + 1;
               end
            end
         end
         for (int c = 1; c < endc; c++) e_busy[c] = 1;
      end
   endtask

   task automatic run_seq(input logic [3:0] mask, input int gap, input int loopc,
                          input int d, input int len, input int a, input int h);
      int endc, pass;
      build(mask, gap, loopc, d, len, a, endc, pass);
      for (int c = 0; c <= endc + 3; c++) begin
         @(posedge io_clk); #1;
         io_start  = (c < h);
         io_abort  = (c == a);
         io_chBusy = drv[c];
         if (c == 0) begin
            io_chMask = mask; io_gap = 32'(gap); io_loopCnt = 16'(loopc);
         end else begin
            io_chMask = 4'($urandom); io_gap = $urandom_range(0, 7); io_loopCnt = 16'($urandom_range(0, 5));
         end
         @(negedge io_clk);
         chk("cyc", {28'd0, io_chEn, io_busy, io_done, io_aborted},
             {28'd0, e_chen[c], e_busy[c], e_done[c], e_abt[c]});
         if (c == 1) chk("pass_clr", 32'(io_passCnt), 32'd0);
      end
      chk("pass", 32'(io_passCnt), 32'(pass));
   endtask

   initial begin
      io_rst_n = 1'b0; io_start = 1'b1; io_abort = 1'b0;
      io_chMask = '0; io_gap = '0; io_loopCnt = '0; io_chBusy = '0;
      repeat (2) @(posedge io_clk);
      @(negedge io_clk);
      chk("rst", {5'd0, io_chEn, io_busy, io_done, io_aborted, io_curCh, io_passCnt}, 32'd0);
      @(posedge io_clk); #1;
      io_rst_n = 1'b1; io_chMask = 4'b0001;
      // Start held high through reset must not launch anything.
      for (int i = 0; i < 3; i++) begin
         @(negedge io_clk);
         chk("rst_hold", {28'd0, io_chEn, io_busy, io_done, io_aborted}, 32'd0);
      end
      @(posedge io_clk); #1; io_start = 1'b0;

      // Directed cases.
      run_seq(4'b0101, 3, 1, 1, 5, NONE, 1);
      run_seq(4'b0000, 2, 1, 1, 5, NONE, 2);
      run_seq(4'b1000, 0, 3, 1, 5, NONE, 1);
      run_seq(4'b0011, 3, 0, 1, 2, 22, 1);   // abort inside GAP of pass 2

      // Reset in the middle of WAIT with start held high.
      @(posedge io_clk); #1;
      io_start = 1'b1; io_chMask = 4'b0001; io_gap = '0; io_loopCnt = '0; io_chBusy = 4'b0001;
      repeat (6) @(posedge io_clk);
      #3 io_rst_n = 1'b0;
      #1 chk("rst_async", {5'd0, io_chEn, io_busy, io_done, io_aborted, io_curCh, io_passCnt}, 32'd0);
      @(posedge io_clk); #1;
      @(posedge io_clk); #1; io_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge io_clk);
         chk("rst_idle", {5'd0, io_chEn, io_busy, io_done, io_aborted, io_curCh, io_passCnt}, 32'd0);
      end
      @(posedge io_clk); #1; io_start = 1'b0;
      @(posedge io_clk); #1; io_start = 1'b1;
      @(negedge io_clk);
      chk("restart_t", {28'd0, io_chEn, io_busy, io_done, io_aborted}, 32'd0);
      @(posedge io_clk); #1; io_abort = 1'b1;
      @(negedge io_clk);
      chk("restart_l", {28'd0, io_chEn, io_busy, io_done, io_aborted}, {28'd0, 4'b0001, 3'b100});
      @(posedge io_clk); #1; io_abort = 1'b0; io_start = 1'b0; io_chBusy = '0;
      @(negedge io_clk);
      chk("restart_a", {28'd0, io_chEn, io_busy, io_done, io_aborted}, 32'd1);

      // Randomized sequences.
      for (int n = 0; n < 40; n++) begin
         logic [3:0] m;
         int g, l, dd, ln, aa, hh;
         m  = 4'($urandom);
         g  = $urandom_range(0, 4);
         l  = $urandom_range(0, 3);
         dd = $urandom_range(0, 5);
         ln = $urandom_range(1, 6);
         hh = $urandom_range(1, 3);
         if (m == 0) aa = NONE;
         else if (l == 0) aa = $urandom_range(1, 120);
         else aa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : NONE;
         run_seq(m, g, l, dd, ln, aa, hh);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
